// File: rtl/imem_loader.sv
// Boot-time loader: assembles a big-endian byte stream (count header + words)
// into instruction-memory writes and holds the core in reset until loaded.
module imem_loader #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  input  logic              i_reload,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_load_done,
  output logic              o_load_err
);

  typedef enum logic [2:0] {CNT_HI, CNT_LO, W_HI, W_LO, DONE, ERR} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_hold;
  logic [15:0]       r_count;
  logic [ADDR_W:0]   r_idx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_core_rst;
  logic              w_accept;
  logic              w_last;
  logic [15:0]       w_n;

  assign w_accept = o_in_ready & i_in_valid;
  assign w_n      = {r_hold, i_in_data};
  // Index is one bit wider than the address so N = DEPTH never wraps it.
  assign w_last   = (17'(r_idx) == ({1'b0, r_count} - 17'd1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= CNT_HI;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_in_ready   = 1'b0;
    o_load_done  = 1'b0;
    o_load_err   = 1'b0;
    case (r_state)
      CNT_HI: begin
        o_in_ready = ~i_rst;
        if (w_accept) w_next_state = CNT_LO;
      end
      CNT_LO: begin
        o_in_ready = ~i_rst;
        if (w_accept) begin
          if (w_n == 16'd0)                    w_next_state = DONE;
          else if ({1'b0, w_n} > 17'(DEPTH))   w_next_state = ERR;
          else                                 w_next_state = W_HI;
        end
      end
      W_HI: begin
        o_in_ready = ~i_rst;
        if (w_accept) w_next_state = W_LO;
      end
      W_LO: begin
        o_in_ready = ~i_rst;
        if (w_accept) w_next_state = w_last ? DONE : W_HI;
      end
      DONE: begin
        o_load_done = 1'b1;
        if (i_reload) w_next_state = CNT_HI;
      end
      ERR: begin
        o_load_err = 1'b1;
        if (i_reload) w_next_state = CNT_HI;
      end
      default: w_next_state = CNT_HI;
    endcase
  end

  // Core reset is released a cycle after DONE so the final write has landed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold      <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_rst  <= 1'b1;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        CNT_HI: if (w_accept) r_hold <= i_in_data;
        CNT_LO: if (w_accept) begin
          r_count <= w_n;
          r_idx   <= '0;
        end
        W_HI:   if (w_accept) r_hold <= i_in_data;
        W_LO:   if (w_accept) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_idx[ADDR_W-1:0];
          r_mem_wdata <= {r_hold, i_in_data};
          r_idx       <= r_idx + (ADDR_W+1)'(1);
        end
        DONE: begin
          if (i_reload) begin
            r_core_rst <= 1'b1;
            r_idx      <= '0;
          end else begin
            r_core_rst <= 1'b0;
          end
        end
        ERR: if (i_reload) r_idx <= '0;
        default: ;
      endcase
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_core_rst  = r_core_rst;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of stream headers with random
// payloads checked against a stream-parsing model, plus hand-written sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic [7:0]  inData = 8'h00;
  logic        inReady;
  logic        reload = 1'b0;
  logic        memWe;
  logic [7:0]  memAddr;
  logic [15:0] memWdata;
  logic        coreRst;
  logic        loadDone;
  logic        loadErr;

  int nVectors = 0;
  int nMiscompares = 0;
  logic [23:0] obsQ[$];

  typedef struct {
    logic [15:0] n;
    bit          stalls;
    bit          expDone;
    bit          expErr;
    int          expWrites;
  } vec_t;

  imem_loader dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(inValid), .i_in_data(inData),
    .o_in_ready(inReady), .i_reload(reload), .o_mem_we(memWe),
    .o_mem_addr(memAddr), .o_mem_wdata(memWdata), .o_core_rst(coreRst),
    .o_load_done(loadDone), .o_load_err(loadErr)
  );

  always #5 clk = ~clk;

  // Every cycle with a write strobe contributes one observed write.
  always @(negedge clk) begin
    if (memWe) obsQ.push_back({memAddr, memWdata});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rstInReady", 32'(inReady), 0);
    checkOutput("rstMemWe", 32'(memWe), 0);
    checkOutput("rstMemAddr", 32'(memAddr), 0);
    checkOutput("rstMemWdata", 32'(memWdata), 0);
    checkOutput("rstCoreRst", 32'(coreRst), 1);
    checkOutput("rstLoadDone", 32'(loadDone), 0);
    checkOutput("rstLoadErr", 32'(loadErr), 0);
  endtask

  task automatic doReset();
    rst = 1'b1; inValid = 1'b0; reload = 1'b0;
    #1;
    checkResetValues();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obsQ.delete();
    checkOutput("readyAfterRst", 32'(inReady), 1);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input bit stalls, output bit ok);
    int guard = 0;
    if (stalls) repeat ($urandom_range(0, 2)) @(negedge clk);
    inValid = 1'b1;
    inData  = b;
    while (!inReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = inReady;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic sendRange(input logic [7:0] q[$], input int first, input int last,
                           input bit stalls, output int accepted);
    bit ok;
    accepted = 0;
    for (int i = first; i <= last; i++) begin
      applyStimulus(q[i], stalls, ok);
      if (ok) accepted++;
    end
  endtask

  function automatic void buildStream(input logic [15:0] n, output logic [7:0] q[$]);
    q.delete();
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    if (n > 16'd256) begin
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < 2 * int'(n); i++) q.push_back(8'($urandom));
    end
  endfunction

  // Reference: parse the stream directly into the expected list of writes.
  task automatic verifyStream(input string tag, input logic [7:0] q[$], input int accepted,
                              input bit expDone, input bit expErr, input int expWrites);
    int n;
    int lim;
    n = int'({q[0], q[1]});
    checkOutput({tag, ".accepted"}, 32'(accepted), expErr ? 2 : q.size());
    checkOutput({tag, ".writes"}, 32'(obsQ.size()), 32'(expWrites));
    lim = (obsQ.size() < expWrites) ? obsQ.size() : expWrites;
    for (int i = 0; i < lim && i < n; i++) begin
      checkOutput({tag, ".addr"}, 32'(obsQ[i][23:16]), 32'(i));
      checkOutput({tag, ".data"}, 32'(obsQ[i][15:0]), 32'({q[2 + 2 * i], q[3 + 2 * i]}));
    end
    checkOutput({tag, ".done"}, 32'(loadDone), 32'(expDone));
    checkOutput({tag, ".err"}, 32'(loadErr), 32'(expErr));
    checkOutput({tag, ".coreRst"}, 32'(coreRst), expDone ? 0 : 1);
    checkOutput({tag, ".inReady"}, 32'(inReady), 0);
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [7:0]  q[$];
    int          acc;
    int          acc2;
    bit          ok;

    vecs.push_back('{16'd3,     1'b0, 1'b1, 1'b0, 3});
    vecs.push_back('{16'd3,     1'b1, 1'b1, 1'b0, 3});
    vecs.push_back('{16'd0,     1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{16'd257,   1'b0, 1'b0, 1'b1, 0});
    vecs.push_back('{16'd1,     1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{16'd256,   1'b1, 1'b1, 1'b0, 256});
    vecs.push_back('{16'd255,   1'b0, 1'b1, 1'b0, 255});
    vecs.push_back('{16'hFFFF,  1'b1, 1'b0, 1'b1, 0});
    vecs.push_back('{16'd7,     1'b1, 1'b1, 1'b0, 7});

    @(negedge clk);
    doReset();

    // Three-word program, checking write/done/core-reset latency.
    q = '{8'h00, 8'h03, 8'h24, 8'h01, 8'h24, 8'h02, 8'h00, 8'h00};
    sendRange(q, 0, 7, 1'b0, acc);
    checkOutput("lat.memWe", 32'(memWe), 1);
    checkOutput("lat.done", 32'(loadDone), 1);
    checkOutput("lat.coreRstHeld", 32'(coreRst), 1);
    checkOutput("lat.addr", 32'(memAddr), 2);
    @(negedge clk);
    checkOutput("lat.memWeOff", 32'(memWe), 0);
    checkOutput("lat.coreRstOff", 32'(coreRst), 0);
    checkOutput("lat.addrHeld", 32'(memAddr), 2);
    checkOutput("lat.dataHeld", 32'(memWdata), 0);
    repeat (2) @(negedge clk);
    verifyStream("plan3", q, acc, 1'b1, 1'b0, 3);

    // Reload from DONE, with a second reload pulse mid-load that must be ignored.
    pulseReload();
    checkOutput("reload.coreRst", 32'(coreRst), 1);
    checkOutput("reload.done", 32'(loadDone), 0);
    checkOutput("reload.inReady", 32'(inReady), 1);
    obsQ.delete();
    q = '{8'h00, 8'h01, 8'h12, 8'h34};
    sendRange(q, 0, 2, 1'b0, acc);
    pulseReload();
    checkOutput("midReload.inReady", 32'(inReady), 1);
    checkOutput("midReload.coreRst", 32'(coreRst), 1);
    sendRange(q, 3, 3, 1'b0, acc2);
    repeat (3) @(negedge clk);
    verifyStream("reload", q, acc + acc2, 1'b1, 1'b0, 1);

    // Oversized header, then reload out of ERR.
    doReset();
    q = '{8'h01, 8'h01, 8'h55, 8'hAA};
    sendRange(q, 0, 3, 1'b0, acc);
    repeat (2) @(negedge clk);
    verifyStream("err257", q, acc, 1'b0, 1'b1, 0);
    pulseReload();
    checkOutput("errReload.err", 32'(loadErr), 0);
    checkOutput("errReload.inReady", 32'(inReady), 1);
    checkOutput("errReload.coreRst", 32'(coreRst), 1);

    // Reset mid-load aborts; the following load must show no residue.
    doReset();
    q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    sendRange(q, 0, 4, 1'b0, acc);
    checkOutput("abort.preAddrData", 32'(memWdata), 32'h1122);
    rst = 1'b1;
    #1;
    checkResetValues();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obsQ.delete();
    q = '{8'h00, 8'h01, 8'hAB, 8'hCD};
    sendRange(q, 0, 3, 1'b1, acc);
    repeat (3) @(negedge clk);
    verifyStream("abort", q, acc, 1'b1, 1'b0, 1);

    // Table of headers with random payloads and random stalls.
    foreach (vecs[v]) begin
      doReset();
      buildStream(vecs[v].n, q);
      sendRange(q, 0, q.size() - 1, vecs[v].stalls, acc);
      repeat (3) @(negedge clk);
      verifyStream($sformatf("vec%0d", v), q, acc, vecs[v].expDone, vecs[v].expErr,
                   vecs[v].expWrites);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle MIPS core.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word into the core's instruction memory write port.
- Holds the core in reset (`core_rst`) until the whole program is loaded, so the core's PC starts at 0 only on a fully valid image.

Parameters:
- `WORD_W`, 16, instruction word width; fixed at 2 bytes.
- `ADDR_W`, 8, instruction memory address width, in words.
- `DEPTH`, 256, instruction memory capacity in words; must satisfy `DEPTH` <= 2^`ADDR_W`.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  single-cycle pulse that restarts loading.
- `mem_we`  out  1  instruction memory write enable, one-cycle pulse.
- `mem_addr`  out  `ADDR_W`  instruction memory word address.
- `mem_wdata`  out  `WORD_W`  instruction word to write.
- `core_rst`  out  1  reset to the single-cycle core, active-high.
- `load_done`  out  1  program loaded; core is running.
- `load_err`  out  1  header word count exceeded `DEPTH`.

Behaviour:
- Reset (async, `rst`=1) values:
  - State = `CNT_HI`.
  - `in_ready`=0 while `rst` is high; it rises combinationally once `rst` is low.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `core_rst`=1, `load_done`=0, `load_err`=0.
  - Internal word counter = 0, count register = 0, byte holding register = 0.
- Handshake: a byte is accepted in a cycle where `in_valid` and `in_ready` are both 1 at the rising edge. `in_ready` is 1 exactly in states `CNT_HI`, `CNT_LO`, `W_HI` and `W_LO`.
- Stream format, all big-endian:
  - 2-byte word count N.
  - Then N words of 2 bytes each.
- FSM, advancing only on accepted bytes unless noted:
  - `CNT_HI`: store byte as N[15:8] -> `CNT_LO`.
  - `CNT_LO`: form N from the stored high byte and this byte, then evaluate:
    - N=0 -> `DONE`.
    - N>`DEPTH` -> `ERR`.
    - Otherwise -> `W_HI`.
  - `W_HI`: store byte as word[15:8] -> `W_LO`.
  - `W_LO`: on the edge that accepts the low byte, register the write:
    - `mem_wdata` = {hi, lo}; `mem_addr` = current word index; `mem_we`=1 for the next cycle only.
    - Increment the word index.
    - If the index just written = N-1 -> `DONE`, else -> `W_HI`.
  - `DONE`: `load_done`=1; `core_rst` is deasserted one cycle after entering `DONE`, i.e. after the final `mem_we` pulse has completed.
  - `ERR`: `load_err`=1, `core_rst` stays 1, no memory writes occur.
- Latency:
  - Low byte accepted at edge k -> `mem_we` high during cycle k..k+1.
  - Last write at edge k -> `load_done` high after edge k.
  - `core_rst` low after edge k+1.
- `mem_addr` and `mem_wdata` hold their last values after the write; only `mem_we` pulses.
- `reload`:
  - Sampled only in `DONE` or `ERR`.
  - Registered effect: `core_rst`=1, `load_done`=0, `load_err`=0, word index=0, state -> `CNT_HI`.
  - Ignored in all other states, i.e. mid-load.
- Boundaries:
  - N=`DEPTH` is legal; the last address written is `DEPTH`-1 and the index never wraps.
  - N=`DEPTH`+1 -> `ERR`.
  - Stalls (`in_valid`=0) may occur between any bytes; state and partial data are held indefinitely.
  - Asserting `rst` mid-load aborts immediately and returns all outputs to their reset values.
- Width rules: N is 16-bit unsigned; the comparison against `DEPTH` is done at 17 bits to avoid truncation.

Test Plan:
- Stream 00 03, 24 01, 24 02, 00 00 with no stalls -> writes (0,0x2401), (1,0x2402), (2,0x0000), one `mem_we` cycle each; `load_done`=1 after the last write; `core_rst` falls one cycle later.
- Same stream with `in_valid` toggled randomly -> identical memory writes and addresses; no extra or missing `mem_we` pulses.
- Header 00 00 -> no `mem_we` ever; `load_done`=1 and `core_rst`=0 within 2 cycles of the second byte.
- Header 01 01 (N=257) with `DEPTH`=256 -> `load_err`=1, `in_ready`=0, `core_rst` held 1; subsequent bytes are not accepted.
- `rst` asserted after 3 data bytes, then a full 1-word load of 00 01 AB CD -> single write (0,0xABCD); no residue from the aborted load.
- After `DONE`, pulse `reload` and send 00 01 12 34 -> `core_rst` re-asserts the cycle after the pulse, write (0,0x1234) occurs, then `core_rst` releases again; a `reload` pulse issued mid-load has no effect.
